// File: rtl/i2c_master_addr_tx.sv
// I2C master address/probe engine: START, 7-bit address + R/W MSB-first, ACK sample, STOP.
// Drives open-drain enables only; every output comes straight from a flop.
module i2c_master_addr_tx #(
   parameter int CLK_DIV = 4
) (
   input  logic       FPGA_clk,
   input  logic       rst,
   input  logic       start,
   input  logic [6:0] addr,
   input  logic       rw,
   input  logic       sda_in,
   output logic       scl_oe,
   output logic       sda_oe,
   output logic       busy,
   output logic       done,
   output logic       ack_ok
);

   localparam int            DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

   typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP} state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic [1:0]    qtr_q, qtr_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          scl_oe_q, scl_oe_d;
   logic          sda_oe_q, sda_oe_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          ack_ok_q, ack_ok_d;
   logic          tick;

   always_comb begin
      tick      = (div_q == DIV_MAX);
      state_d   = state_q;
      div_d     = div_q;
      qtr_d     = qtr_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      ack_ok_d  = ack_ok_q;
      done_d    = 1'b0;

      if (state_q == IDLE) begin
         if (start) begin
            state_d   = START;
            shift_d   = {addr, rw};
            bit_cnt_d = 3'd7;
            ack_ok_d  = 1'b0;
            div_d     = '0;
            qtr_d     = 2'd0;
         end
      end else begin
         div_d = tick ? '0 : div_q + 1'b1;
         if (tick) begin
            qtr_d = qtr_q + 2'd1;
            // SDA has been stable for a full SCL-high quarter by the q2->q3 tick
            if (state_q == ACK && qtr_q == 2'd2)
               ack_ok_d = ~sda_in;
            if (qtr_q == 2'd3) begin
               case (state_q)
                  START: state_d = BIT;
                  BIT: begin
                     shift_d   = {shift_q[6:0], 1'b0};
                     bit_cnt_d = bit_cnt_q - 3'd1;
                     if (bit_cnt_q == 3'd0)
                        state_d = ACK;
                  end
                  ACK:  state_d = STOP;
                  STOP: begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end
                  default: state_d = IDLE;
               endcase
            end
         end
      end

      // Line enables decoded from the next state so they register in step with it
      scl_oe_d = 1'b0;
      sda_oe_d = 1'b0;
      case (state_d)
         START: begin
            scl_oe_d = (qtr_d == 2'd3);
            sda_oe_d = (qtr_d != 2'd0);
         end
         BIT: begin
            scl_oe_d = ~qtr_d[1];
            sda_oe_d = ~shift_d[7];
         end
         ACK: begin
            scl_oe_d = ~qtr_d[1];
            sda_oe_d = 1'b0;
         end
         STOP: begin
            scl_oe_d = ~qtr_d[1];
            sda_oe_d = (qtr_d != 2'd3);
         end
         default: begin
            scl_oe_d = 1'b0;
            sda_oe_d = 1'b0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge FPGA_clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         div_q     <= '0;
         qtr_q     <= 2'd0;
         bit_cnt_q <= 3'd7;
         shift_q   <= 8'd0;
         scl_oe_q  <= 1'b0;
         sda_oe_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ack_ok_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         qtr_q     <= qtr_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         scl_oe_q  <= scl_oe_d;
         sda_oe_q  <= sda_oe_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         ack_ok_q  <= ack_ok_d;
      end
   end

   assign scl_oe = scl_oe_q;
   assign sda_oe = sda_oe_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign ack_ok = ack_ok_q;

endmodule

// File: doc/i2c_master_addr_tx.md
Name: i2c_master_addr_tx

Overview:
Master-side address transmitter for the I2C Interface IP. It is the initiator counterpart of the slave address decoder.
- On a start request it generates a START condition, then shifts out the 7-bit slave address plus the R/W bit MSB-first on SDA, then samples the slave ACK, then generates STOP.
- Drives open-drain enables only. Serves as the address/probe phase engine for the master controller.

Parameters:
CLK_DIV, 4, FPGA_clk cycles per SCL quarter-period; legal range ≥1; divider counter width $clog2(CLK_DIV) (min 1).

Ports:
FPGA_clk  input  1  system clock
rst  input  1  asynchronous active-high reset
start  input  1  single-cycle request; sampled only when busy=0
addr  input  7  slave address, latched on accepted start
rw  input  1  R/W bit (1=read), latched on accepted start
sda_in  input  1  SDA line value (post-synchroniser, from pad)
scl_oe  output  1  1 = pull SCL low, 0 = release
sda_oe  output  1  1 = pull SDA low, 0 = release
busy  output  1  transaction in progress
done  output  1  one-cycle pulse at transaction end
ack_ok  output  1  1 = slave ACKed last address; held until next accepted start

Behaviour:
Clock and reset:
- One clock (FPGA_clk). Reset is asynchronous, active-high (rst).
- Reset forces: state IDLE, scl_oe=0, sda_oe=0, busy=0, done=0, ack_ok=0, divider=0, bit counter=7, shift register=0.
- Reset mid-transaction releases both lines immediately, with no STOP generated.

Timing base:
- Quarter tick when divider == CLK_DIV-1; divider then wraps to 0.
- Divider runs only outside IDLE and is cleared on entry to START.
- Each phase below is 4 quarters, q0..q3. Phase/quarter advance happens on ticks.

FSM states: IDLE, START, BIT, ACK, STOP.
- IDLE: scl_oe=0, sda_oe=0, busy=0.
  - start=1 → latch shift={addr,rw}, bit counter=7, clear ack_ok, busy=1, go to START on the same edge.
  - start while busy=1 is ignored; no queuing.
- START:
  - q0: SCL and SDA released.
  - q1–q2: sda_oe=1 (SDA falls while SCL high).
  - q3: scl_oe=1.
  - → BIT.
- BIT (repeated for bit counter 7..0):
  - q0–q1: scl_oe=1, sda_oe=~shift[7], set at entry to q0 and stable through q3.
  - q2–q3: scl_oe=0.
  - End of q3: shift left 1; bit counter decrements (3-bit). Leaving with counter 0 → ACK (counter wraps to 7, unused).
- ACK:
  - q0–q1: scl_oe=1, sda_oe=0.
  - q2–q3: scl_oe=0.
  - At the q2→q3 tick: ack_ok <= ~sda_in.
  - → STOP unconditionally (NACK also ends in STOP).
- STOP:
  - q0–q1: scl_oe=1, sda_oe=1.
  - q2: scl_oe=0, sda_oe=1.
  - q3: sda_oe=0 (SDA rises while SCL high).
  - End of q3 → IDLE, done=1 for exactly one cycle, busy=0 in that same cycle.

Latency:
- Start accepted at edge E0. Final tick at E0 + 44*CLK_DIV cycles.
- done is high in the cycle after that edge.
- Total SCL high pulses = 9 (8 data + ACK).

Limits:
- No clock stretching and no arbitration; SCL is not read back.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- CLK_DIV=4, addr=0x50, rw=0, sda_in driven low during ACK → SDA bits during SCL-high windows = 1,0,1,0,0,0,0,0; START precedes and STOP follows; ack_ok=1; done pulse exactly 176 cycles after the start edge; busy low thereafter.
- addr=0x2A, rw=1, sda_in held high (NACK) → bits 0,1,0,1,0,1,0,1; ack_ok=0; STOP still generated; done pulses once.
- start re-pulsed while busy=1, mid-BIT → ignored; waveform and done timing identical to an undisturbed run.
- rst asserted in BIT q1 of bit 4 → scl_oe=0, sda_oe=0, busy=0 within the same cycle, with no clock edge required; a subsequent start runs a full correct transaction.
- CLK_DIV=1, addr=0x7F, rw=1 → SDA released on all 8 bits; done exactly 44 cycles after the start edge; SDA never changes while SCL is high except at START and STOP.
- Back-to-back: start pulsed in the cycle done=1 → accepted (busy=0); a new START begins with no lost cycles; ack_ok cleared at acceptance.
